// File: rtl/command_framer.sv
// Byte-stream command framer: recognises HEADER,HI,LO,CHK frames, checks CHK == HI^LO
// and emits the 16-bit command with a one-cycle strobe, counting framing errors.
`timescale 1ns/1ps
module command_framer #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] command,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [7:0]           hi;
  logic [7:0]           lo;
  logic [TIMEOUT_W-1:0] tmo_cnt;

  logic timeout_hit;
  logic accept_chk;
  logic chk_ok;
  logic err_event;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = (state != S_IDLE) && !rx_valid && (tmo_cnt == TIMEOUT_LAST);
  assign accept_chk  = rx_valid && (state == S_CHK);
  assign chk_ok      = (rx_data == (hi ^ lo));
  assign err_event   = (accept_chk && !chk_ok) || timeout_hit;
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (rx_valid && rx_data == HEADER) state_nxt = S_HI;
      S_HI: begin
        if (rx_valid)         state_nxt = S_LO;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_LO: begin
        if (rx_valid)         state_nxt = S_CHK;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      default: begin
        if (rx_valid || timeout_hit) state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame state, captured bytes and inter-byte timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hi      <= 8'h00;
      lo      <= 8'h00;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (rx_valid && state == S_HI) hi <= rx_data;
      if (rx_valid && state == S_LO) lo <= rx_data;
      if (state == S_IDLE || rx_valid || timeout_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Registered outputs, one cycle after the CHK byte or the timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      command   <= 16'h0000;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'h00;
    end else begin
      cmd_valid <= accept_chk && chk_ok;
      frame_err <= err_event;
      if (accept_chk && chk_ok) command <= {hi, lo};
      if (err_event) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_command_framer.sv
// Directed bench for command_framer with a short timeout so expiry paths are reachable.
`timescale 1ns/1ps
module tb_command_framer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] command;
  logic        cmd_valid;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  int n_vec;
  int n_miss;

  command_framer #(
    .HEADER(8'hA5),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .command(command),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .err_count(err_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one byte for one cycle; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic frame4(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input logic exp_cv,
                        input logic [15:0] exp_cmd, input logic [7:0] exp_cnt);
    send(b0); send(b1); send(b2); send(b3);
    chk({tag, ".cmd_valid"}, 16'(cmd_valid), 16'(exp_cv));
    chk({tag, ".frame_err"}, 16'(frame_err), 16'(!exp_cv));
    chk({tag, ".command"}, command, exp_cmd);
    chk({tag, ".err_count"}, 16'(err_count), 16'(exp_cnt));
  endtask

  initial begin
    int first_err;
    logic busy_at15;
    n_vec    = 0;
    n_miss   = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.command", command, 16'h0000);
    chk("rst.cmd_valid", 16'(cmd_valid), 16'd0);
    chk("rst.frame_err", 16'(frame_err), 16'd0);
    chk("rst.err_count", 16'(err_count), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Valid frame, then strobe must be exactly one cycle wide
    frame4("f1280", 8'hA5, 8'h12, 8'h80, 8'h92, 1'b1, 16'h1280, 8'd0);
    @(posedge clk); #1;
    chk("f1280.pulse_w", 16'(cmd_valid), 16'd0);

    frame4("bad93", 8'hA5, 8'h12, 8'h80, 8'h93, 1'b0, 16'h1280, 8'd1);
    @(posedge clk); #1;
    chk("bad93.pulse_w", 16'(frame_err), 16'd0);

    // Back-to-back: next header arrives while cmd_valid is high
    frame4("f504c", 8'hA5, 8'h50, 8'h4C, 8'h1C, 1'b1, 16'h504C, 8'd1);
    frame4("f4000b2b", 8'hA5, 8'h40, 8'h00, 8'h40, 1'b1, 16'h4000, 8'd1);
    @(posedge clk); #1;

    // Noise before header is discarded silently
    send(8'h00); chk("noise00.busy", 16'(busy), 16'd0);
    send(8'hFF); chk("noiseFF.busy", 16'(busy), 16'd0);
    send(8'h3C); chk("noise3C.busy", 16'(busy), 16'd0);
    chk("noise.frame_err", 16'(frame_err), 16'd0);
    send(8'hA5); chk("noiseA5.busy", 16'(busy), 16'd1);
    send(8'h50); send(8'h00); send(8'h50);
    chk("noise.cmd_valid", 16'(cmd_valid), 16'd1);
    chk("noise.command", command, 16'h5000);
    chk("noise.err_count", 16'(err_count), 16'd1);
    @(posedge clk); #1;

    // Timeout: FRAME_ERR expected 16 cycles after the last byte
    send(8'hA5); send(8'h12);
    first_err = 0;
    busy_at15 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 15) busy_at15 = busy;
      if (frame_err) begin
        first_err = n;
        break;
      end
    end
    chk("tmo.latency", 16'(first_err), 16'd16);
    chk("tmo.busy_before", 16'(busy_at15), 16'd1);
    chk("tmo.busy_after", 16'(busy), 16'd0);
    chk("tmo.err_count", 16'(err_count), 16'd2);
    chk("tmo.cmd_valid", 16'(cmd_valid), 16'd0);
    @(posedge clk); #1;
    chk("tmo.pulse_w", 16'(frame_err), 16'd0);

    // Byte on the expiry cycle is accepted instead of timing out
    send(8'hA5); send(8'h12);
    repeat (15) @(posedge clk);
    #1;
    chk("edge1.frame_err", 16'(frame_err), 16'd0);
    send(8'h80);
    chk("edge2.frame_err", 16'(frame_err), 16'd0);
    chk("edge2.busy", 16'(busy), 16'd1);
    repeat (15) @(posedge clk);
    #1;
    send(8'h92);
    chk("edge3.cmd_valid", 16'(cmd_valid), 16'd1);
    chk("edge3.command", command, 16'h1280);
    chk("edge3.err_count", 16'(err_count), 16'd2);
    @(posedge clk); #1;

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      send(8'hA5); send(8'h12); send(8'h80); send(8'h93);
      if (i == 250) chk("sat.mid", 16'(err_count), 16'h00FD);
    end
    chk("sat.err_count", 16'(err_count), 16'h00FF);
    @(posedge clk); #1;
    frame4("sat_ok", 8'hA5, 8'h50, 8'h4C, 8'h1C, 1'b1, 16'h504C, 8'hFF);
    @(posedge clk); #1;

    // Asynchronous reset mid-frame
    send(8'hA5); send(8'h12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.command", command, 16'h0000);
    chk("arst.err_count", 16'(err_count), 16'd0);
    chk("arst.busy", 16'(busy), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h80); send(8'h92);
    chk("arst.cmd_valid", 16'(cmd_valid), 16'd0);
    chk("arst.frame_err", 16'(frame_err), 16'd0);
    chk("arst.busy2", 16'(busy), 16'd0);
    @(posedge clk); #1;
    chk("arst.cmd_valid2", 16'(cmd_valid), 16'd0);
    chk("arst.command2", command, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
